right_rot: RTL and testbench
============================

# right_rot

16-bit right-rotate unit for the processor's shift/rotate datapath (ROR-class instructions). Rotates a 16-bit operand right by 0–15 positions; bits shifted out of bit 0 re-enter at bit 15. It is built as a 4-stage logarithmic barrel rotator and sits beside the left/right shifters feeding the ALU result mux. The output is combinational by default, with an optional registered output stage.

## Interface
- No parameters; width fixed at 16 data bits, 4 amount bits.
- clk  input  1  system clock; used only when the output register is compiled in.
- rst_n  input  1  reset, asynchronous and active-low.
- RR_In  input  16  operand to rotate.
- RR_Amt  input  4  rotate amount, unsigned 0–15.
- RR_Vld_In  input  1  operand/amount valid qualifier.
- RR_Out  output  16  rotated result.
- RR_Vld_Out  output  1  result valid qualifier.

## Operation
- RR_Out = (RR_In >> RR_Amt) | (RR_In << (16 - RR_Amt)), computed within 16 bits.
- Stage structure, in order: stage 0 rotates by 1 if RR_Amt[0], stage 1 by 2 if RR_Amt[1], stage 2 by 4 if RR_Amt[2], stage 3 by 8 if RR_Amt[3].
  - Each stage is a 16-wide 2:1 mux: out[i] = sel ? in[(i+k) mod 16] : in[i].
- RR_Amt = 0: RR_Out equals RR_In exactly.
- RR_Amt = 15: equivalent to rotate-left by 1.
- Rotation is lossless: the popcount of RR_Out always equals the popcount of RR_In.
- RR_Vld_Out follows RR_Vld_In through the same path as the data.
- Data is computed regardless of RR_Vld_In; valid only qualifies it.
- No X-propagation masking: unknown inputs may yield unknown outputs.

## Timing
- Default (combinational) build:
  - RR_Out and RR_Vld_Out respond within the same cycle, with zero latency.
  - clk and rst_n do not affect the outputs.
- Registered build:
  - Outputs are captured on the rising edge of clk, giving 1-cycle latency.
  - A new operand is accepted every cycle; there is no backpressure.
- Reset (registered build):
  - While rst_n = 0, RR_Out = 16'h0000 and RR_Vld_Out = 0, asynchronously.
  - The first capture occurs on the first rising clk edge after rst_n deasserts.
  - Asserting reset mid-stream discards the in-flight result.
- Simultaneous change of RR_In and RR_Amt: the output reflects both new values, with no ordering dependency.

## Configuration
- Macro RR_REG_OUT_EN.
  - Defined: a register stage (async active-low reset to zero) is placed after stage 3 on RR_Out and RR_Vld_Out; behaviour is as in the registered build under Timing.
  - Undefined: fully combinational; clk and rst_n remain as ports but are unused.

## Test plan
- RR_Amt=0, RR_In=16'hEC21 -> RR_Out=16'hEC21.
- RR_Amt=4, RR_In=16'h9F0A -> RR_Out=16'hA9F0.
- RR_Amt=7, RR_In=16'hC2E5 -> RR_Out=16'hCB85.
- RR_Amt=15, RR_In=16'hF0F0 -> RR_Out=16'hE1E1.
- Exhaustive: all 16 amounts × random operands checked against the reference formula and for popcount preservation.
  - Single-bit walk: RR_In=16'h0001 with RR_Amt=k -> only bit (16-k) mod 16 is set.
- Registered build:
  - With rst_n=0, RR_Out=0 and RR_Vld_Out=0.
  - After release, applying RR_In=16'h9F0A, RR_Amt=4, RR_Vld_In=1 -> RR_Out=16'hA9F0 and RR_Vld_Out=1 one clk edge later.
  - Asserting rst_n=0 asynchronously mid-cycle clears both outputs immediately.

Source files
------------

// File: rtl/right_rot.sv
// 16-bit right-rotate unit: four-stage logarithmic barrel rotator (1/2/4/8).
// Define RR_REG_OUT_EN to add a reset-to-zero output register after stage 3.
module right_rot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] RR_In,
    input  logic [3:0]  RR_Amt,
    input  logic        RR_Vld_In,
    output logic [15:0] RR_Out,
    output logic        RR_Vld_Out
);

    // w_stage[s] is the operand after stages 0..s-1; w_stage[4] is fully rotated.
    logic [15:0] w_stage [0:4];

    assign w_stage[0] = RR_In;

    for (genvar s = 0; s < 4; s++) begin : g_stage
        localparam int K = 1 << s;
        // out[i] = in[(i+K) mod 16]: the low K bits wrap into the top.
        assign w_stage[s+1] = RR_Amt[s] ? {w_stage[s][K-1:0], w_stage[s][15:K]}
                                        : w_stage[s];
    end

`ifdef RR_REG_OUT_EN
    logic [15:0] r_out;
    logic        r_vld;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 16'h0000;
            r_vld <= 1'b0;
        end else begin
            r_out <= w_stage[4];
            r_vld <= RR_Vld_In;
        end
    end

    assign RR_Out     = r_out;
    assign RR_Vld_Out = r_vld;
`else
    // Clock and reset are kept on the port list for a uniform footprint.
    logic w_unused;
    assign w_unused   = &{1'b0, clk, rst_n};

    assign RR_Out     = w_stage[4];
    assign RR_Vld_Out = RR_Vld_In;
`endif

endmodule

// File: tb/tb_right_rot.sv
// Directed self-checking bench for right_rot; follows RR_REG_OUT_EN to pick
// combinational or one-cycle-latency sampling.
module tb_right_rot;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rr_in     = 16'h0000;
    logic [3:0]  rr_amt    = 4'd0;
    logic        rr_vld_in = 1'b0;
    logic [15:0] rr_out;
    logic        rr_vld_out;

    int n_vec = 0;
    int n_err = 0;

    right_rot dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RR_In      (rr_in),
        .RR_Amt     (rr_amt),
        .RR_Vld_In  (rr_vld_in),
        .RR_Out     (rr_out),
        .RR_Vld_Out (rr_vld_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_ror(input logic [15:0] x, input logic [3:0] a);
        logic [31:0] d;
        d = {x, x} >> a;
        return d[15:0];
    endfunction

    // Drive one operand and wait until its result is observable.
    task automatic apply(input logic [15:0] d, input logic [3:0] a, input logic v);
        rr_in     = d;
        rr_amt    = a;
        rr_vld_in = v;
`ifdef RR_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    typedef struct {
        logic [15:0] din;
        logic [3:0]  amt;
        logic [15:0] dout;
    } vec_t;

    vec_t dir_tbl [6];

    initial begin
        dir_tbl[0] = '{16'hEC21, 4'd0,  16'hEC21};
        dir_tbl[1] = '{16'h9F0A, 4'd4,  16'hA9F0};
        dir_tbl[2] = '{16'hC2E5, 4'd7,  16'hCB85};
        dir_tbl[3] = '{16'hF0F0, 4'd15, 16'hE1E1};
        dir_tbl[4] = '{16'h8001, 4'd1,  16'hC000};
        dir_tbl[5] = '{16'h1234, 4'd8,  16'h3412};

        // Reset behaviour.
        rr_in = 16'hEC21; rr_amt = 4'd0; rr_vld_in = 1'b1;
        #12;
`ifdef RR_REG_OUT_EN
        @(posedge clk); #1;
        check("rst_out", {16'h0, rr_out}, 32'h0);
        check("rst_vld", {31'h0, rr_vld_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
`else
        check("rst_ignored_out", {16'h0, rr_out}, 32'h0000_EC21);
        check("rst_ignored_vld", {31'h0, rr_vld_out}, 32'h1);
        rst_n = 1'b1;
`endif

        // Directed vectors.
        foreach (dir_tbl[i]) begin
            apply(dir_tbl[i].din, dir_tbl[i].amt, 1'b1);
            check($sformatf("dir%0d_out", i), {16'h0, rr_out}, {16'h0, dir_tbl[i].dout});
            check($sformatf("dir%0d_vld", i), {31'h0, rr_vld_out}, 32'h1);
        end

        // Data is computed even when valid is low.
        apply(16'h9F0A, 4'd4, 1'b0);
        check("novld_out", {16'h0, rr_out}, 32'h0000_A9F0);
        check("novld_vld", {31'h0, rr_vld_out}, 32'h0);

        // Single-bit walk.
        for (int k = 0; k < 16; k++) begin
            logic [15:0] exp_w;
            exp_w = 16'h0001 << ((16 - k) % 16);
            apply(16'h0001, 4'(k), 1'b1);
            check($sformatf("walk%0d", k), {16'h0, rr_out}, {16'h0, exp_w});
        end

        // Every amount against the reference formula and popcount.
        for (int a = 0; a < 16; a++) begin
            for (int r = 0; r < 3; r++) begin
                logic [15:0] op;
                op = 16'($urandom);
                apply(op, 4'(a), 1'b1);
                check($sformatf("rnd_a%0d_%h", a, op), {16'h0, rr_out}, {16'h0, ref_ror(op, 4'(a))});
                check($sformatf("pop_a%0d_%h", a, op), $countones(rr_out), $countones(op));
            end
        end

`ifdef RR_REG_OUT_EN
        // Asynchronous mid-cycle reset clears outputs before any edge.
        apply(16'h9F0A, 4'd4, 1'b1);
        check("pre_arst_out", {16'h0, rr_out}, 32'h0000_A9F0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", {16'h0, rr_out}, 32'h0);
        check("arst_vld", {31'h0, rr_vld_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(16'hF0F0, 4'd15, 1'b1);
        check("post_arst_out", {16'h0, rr_out}, 32'h0000_E1E1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
